// File: rtl/acc_wb_splitter.sv
// Registers accelerator responses and splits dual write-backs into two single-register beats.
// Optional: define ACC_WB_SPLIT_DROP_X0_EN to suppress every beat that targets x0.
module acc_wb_splitter #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DataWidth-1:0] p_data0_i,
  input  logic [DataWidth-1:0] p_data1_i,
  input  logic                 p_dual_writeback_i,
  input  logic [IdWidth-1:0]   p_id_i,
  input  logic [4:0]           p_rd_i,
  input  logic                 p_error_i,
  input  logic                 p_valid_i,
  output logic                 p_ready_o,
  output logic [DataWidth-1:0] wb_data_o,
  output logic [4:0]           wb_rd_o,
  output logic [IdWidth-1:0]   wb_id_o,
  output logic                 wb_error_o,
  output logic                 wb_last_o,
  output logic                 wb_valid_o,
  input  logic                 wb_ready_i,
  output logic                 busy_o
);

  typedef enum logic [1:0] {EMPTY = 2'd0, LAST = 2'd1, FIRST = 2'd2} state_e;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [4:0]           rd;
  } beat_t;

  state_e             state_q, state_d, ld_state;
  beat_t              out_q, out_d, side_q, side_d, ld_beat;
  logic [IdWidth-1:0] id_q, id_d;
  logic               err_q, err_d, last_q, last_d, ld_last;
  logic               accept;
  logic [4:0]         rd_inc;

  assign p_ready_o = (state_q == EMPTY) | ((state_q == LAST) & wb_ready_i);
  assign accept    = p_valid_i & p_ready_o;
  assign rd_inc    = p_rd_i + 5'd1;

  // What a freshly accepted response puts into the output register.
  always_comb begin
    ld_state = p_dual_writeback_i ? FIRST : LAST;
    ld_beat  = {p_data0_i, p_rd_i};
    ld_last  = ~p_dual_writeback_i;
`ifdef ACC_WB_SPLIT_DROP_X0_EN
    if (p_rd_i == 5'd0) begin
      if (p_dual_writeback_i) begin
        ld_state = LAST;
        ld_beat  = {p_data1_i, rd_inc};
        ld_last  = 1'b1;
      end else begin
        ld_state = EMPTY;
      end
    end else if (p_dual_writeback_i && rd_inc == 5'd0) begin
      ld_state = LAST;
      ld_last  = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    side_d  = side_q;
    id_d    = id_q;
    err_d   = err_q;
    last_d  = last_q;
    if (accept) begin
      state_d = ld_state;
      out_d   = ld_beat;
      last_d  = ld_last;
      id_d    = p_id_i;
      err_d   = p_error_i;
      if (p_dual_writeback_i) side_d = {p_data1_i, rd_inc};
    end else if (wb_ready_i) begin
      // id and error stay with the second beat of a dual.
      if (state_q == FIRST) begin
        state_d = LAST;
        out_d   = side_q;
        last_d  = 1'b1;
      end else if (state_q == LAST) begin
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      out_q   <= '0;
      side_q  <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      side_q  <= side_d;
      id_q    <= id_d;
      err_q   <= err_d;
      last_q  <= last_d;
    end
  end

  assign wb_data_o  = out_q.data;
  assign wb_rd_o    = out_q.rd;
  assign wb_id_o    = id_q;
  assign wb_error_o = err_q;
  assign wb_last_o  = last_q;
  assign wb_valid_o = (state_q != EMPTY);
  assign busy_o     = wb_valid_o;

endmodule

// File: tb/tb_acc_wb_splitter.sv
// Bench for acc_wb_splitter: directed vector table, hand sequences, and random traffic vs a beat-queue model.
module tb_acc_wb_splitter;

`ifdef ACC_WB_SPLIT_DROP_X0_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] p_data0_i, p_data1_i;
  logic        p_dual_writeback_i;
  logic [3:0]  p_id_i;
  logic [4:0]  p_rd_i;
  logic        p_error_i, p_valid_i, p_ready_o;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_rd_o;
  logic [3:0]  wb_id_o;
  logic        wb_error_o, wb_last_o, wb_valid_o, wb_ready_i, busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  acc_wb_splitter #(.DataWidth(32), .IdWidth(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .p_data0_i(p_data0_i), .p_data1_i(p_data1_i),
    .p_dual_writeback_i(p_dual_writeback_i), .p_id_i(p_id_i), .p_rd_i(p_rd_i),
    .p_error_i(p_error_i), .p_valid_i(p_valid_i), .p_ready_o(p_ready_o),
    .wb_data_o(wb_data_o), .wb_rd_o(wb_rd_o), .wb_id_o(wb_id_o),
    .wb_error_o(wb_error_o), .wb_last_o(wb_last_o), .wb_valid_o(wb_valid_o),
    .wb_ready_i(wb_ready_i), .busy_o(busy_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: every response expands to a list of beats, x0 beats optionally
  // filtered, the surviving final beat flagged last. Pending beats live in a queue.
  typedef struct packed {
    logic [4:0]  rd;
    logic [3:0]  id;
    logic        err;
    logic        last;
    logic [31:0] data;
  } beat_t;

  beat_t expq[$];

  task automatic model_push(input logic dual, input logic [4:0] rd, input logic [31:0] d0,
                            input logic [31:0] d1, input logic [3:0] id, input logic err);
    beat_t       b[$];
    logic [4:0]  rds[2];
    logic [31:0] ds[2];
    rds[0] = rd;
    rds[1] = rd + 5'd1;
    ds[0]  = d0;
    ds[1]  = d1;
    for (int i = 0; i < (dual ? 2 : 1); i++)
      if (!(DROP && rds[i] == 5'd0)) b.push_back('{rds[i], id, err, 1'b0, ds[i]});
    if (b.size() > 0) b[b.size()-1].last = 1'b1;
    foreach (b[i]) expq.push_back(b[i]);
  endtask

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      expq.delete();
      chk("rst_wb_valid", wb_valid_o, 1'b0);
    end else begin
      chk("mon_wb_valid", wb_valid_o, expq.size() != 0);
      chk("mon_busy", busy_o, expq.size() != 0);
      chk("mon_p_ready", p_ready_o, (expq.size() == 0) || (expq.size() == 1 && wb_ready_i));
      if (wb_valid_o && expq.size() != 0) begin
        chk("mon_beat", {wb_rd_o, wb_id_o, wb_error_o, wb_last_o, wb_data_o}, expq[0]);
        if (wb_ready_i) void'(expq.pop_front());
      end
      if (p_valid_i && p_ready_o)
        model_push(p_dual_writeback_i, p_rd_i, p_data0_i, p_data1_i, p_id_i, p_error_i);
    end
  end

  typedef struct {
    logic        dual;
    logic [4:0]  rd;
    logic [31:0] d0, d1;
    logic [3:0]  id;
    logic        err;
    int          nb;
    logic [4:0]  erd[2];
    logic [31:0] edat[2];
  } vec_t;

  vec_t vt[7];

  task automatic setv(input int k, input logic dual, input logic [4:0] rd, input logic [31:0] d0,
                      input logic [31:0] d1, input logic [3:0] id, input logic err, input int nb,
                      input logic [4:0] r0, input logic [31:0] e0, input logic [4:0] r1,
                      input logic [31:0] e1);
    vt[k].dual = dual; vt[k].rd = rd; vt[k].d0 = d0; vt[k].d1 = d1;
    vt[k].id = id; vt[k].err = err; vt[k].nb = nb;
    vt[k].erd[0] = r0; vt[k].edat[0] = e0; vt[k].erd[1] = r1; vt[k].edat[1] = e1;
  endtask

  task automatic drive(input logic dual, input logic [4:0] rd, input logic [31:0] d0,
                       input logic [31:0] d1, input logic [3:0] id, input logic err);
    p_valid_i = 1'b1; p_dual_writeback_i = dual; p_rd_i = rd;
    p_data0_i = d0; p_data1_i = d1; p_id_i = id; p_error_i = err;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   k;
    setv(0, 1'b0, 5'd5,  32'hDEADBEEF, 32'h0, 4'd3, 1'b0, 1, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
    setv(1, 1'b1, 5'd10, 32'h11, 32'h22, 4'd7, 1'b1, 2, 5'd10, 32'h11, 5'd11, 32'h22);
    setv(5, 1'b0, 5'd31, 32'hFFFFFFFF, 32'h0, 4'd0, 1'b1, 1, 5'd31, 32'hFFFFFFFF, 5'd0, 32'h0);
    setv(6, 1'b1, 5'd30, 32'h1, 32'h2, 4'd9, 1'b0, 2, 5'd30, 32'h1, 5'd31, 32'h2);
`ifdef ACC_WB_SPLIT_DROP_X0_EN
    setv(2, 1'b1, 5'd31, 32'hA5A5, 32'h5A5A, 4'd2, 1'b0, 1, 5'd31, 32'hA5A5, 5'd0, 32'h0);
    setv(3, 1'b0, 5'd0,  32'hCAFE, 32'h0, 4'd1, 1'b1, 0, 5'd0, 32'h0, 5'd0, 32'h0);
    setv(4, 1'b1, 5'd0,  32'h1234, 32'h5678, 4'd15, 1'b0, 1, 5'd1, 32'h5678, 5'd0, 32'h0);
`else
    setv(2, 1'b1, 5'd31, 32'hA5A5, 32'h5A5A, 4'd2, 1'b0, 2, 5'd31, 32'hA5A5, 5'd0, 32'h5A5A);
    setv(3, 1'b0, 5'd0,  32'hCAFE, 32'h0, 4'd1, 1'b1, 1, 5'd0, 32'hCAFE, 5'd0, 32'h0);
    setv(4, 1'b1, 5'd0,  32'h1234, 32'h5678, 4'd15, 1'b0, 2, 5'd0, 32'h1234, 5'd1, 32'h5678);
`endif

    rst_ni = 1'b0; p_valid_i = 1'b0; wb_ready_i = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 32'h0, 4'd0, 1'b0); p_valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_outputs", {wb_valid_o, wb_rd_o, wb_id_o, wb_error_o, wb_last_o, wb_data_o, busy_o}, 64'h0);
    rst_ni = 1'b1;
    #1 chk("reset_p_ready", p_ready_o, 1'b1);
    @(posedge clk_i); #1;

    // Directed vector table, wb_ready held high.
    for (int v = 0; v < 7; v++) begin
      drive(vt[v].dual, vt[v].rd, vt[v].d0, vt[v].d1, vt[v].id, vt[v].err);
      chk($sformatf("tbl%0d_accept", v), p_ready_o, 1'b1);
      @(posedge clk_i); #1;
      p_valid_i = 1'b0;
      for (int b = 0; b < vt[v].nb; b++) begin
        chk($sformatf("tbl%0d_beat%0d", v, b),
            {wb_valid_o, wb_rd_o, wb_id_o, wb_error_o, wb_last_o, wb_data_o},
            {1'b1, vt[v].erd[b], vt[v].id, vt[v].err, (b == vt[v].nb - 1), vt[v].edat[b]});
        chk($sformatf("tbl%0d_pready%0d", v, b), p_ready_o, (b == vt[v].nb - 1));
        @(posedge clk_i); #1;
      end
      chk($sformatf("tbl%0d_idle", v), wb_valid_o, 1'b0);
    end

    // Eight back-to-back singles: one write per cycle, in order.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 5'(i + 1), 32'(256 + i), 32'h0, 4'(i), 1'b0);
      @(posedge clk_i); #1;
      chk($sformatf("b2b%0d_beat", i), {wb_valid_o, wb_rd_o, wb_id_o, wb_last_o, wb_data_o},
          {1'b1, 5'(i + 1), 4'(i), 1'b1, 32'(256 + i)});
      chk($sformatf("b2b%0d_pready", i), p_ready_o, 1'b1);
    end
    p_valid_i = 1'b0;
    @(posedge clk_i); #1;
    chk("b2b_idle", wb_valid_o, 1'b0);

    // Backpressure with the next response waiting.
    drive(1'b0, 5'd7, 32'hAAAA0007, 32'h0, 4'd5, 1'b0);
    @(posedge clk_i); #1;
    wb_ready_i = 1'b0;
    drive(1'b0, 5'd8, 32'hAAAA0008, 32'h0, 4'd6, 1'b1);
    repeat (5) begin
      @(posedge clk_i); #1;
      chk("bp_hold", {wb_valid_o, wb_rd_o, wb_id_o, wb_error_o, wb_last_o, wb_data_o},
          {1'b1, 5'd7, 4'd5, 1'b0, 1'b1, 32'hAAAA0007});
      chk("bp_pready", p_ready_o, 1'b0);
    end
    wb_ready_i = 1'b1;
    #1 chk("bp_release_pready", p_ready_o, 1'b1);
    @(posedge clk_i); #1;
    p_valid_i = 1'b0;
    chk("bp_next", {wb_valid_o, wb_rd_o, wb_id_o, wb_error_o, wb_last_o, wb_data_o},
        {1'b1, 5'd8, 4'd6, 1'b1, 1'b1, 32'hAAAA0008});
    @(posedge clk_i); #1;

    // Reset while holding the first beat of a dual.
    wb_ready_i = 1'b0;
    drive(1'b1, 5'd12, 32'hF00D0001, 32'hF00D0002, 4'd4, 1'b0);
    @(posedge clk_i); #1;
    p_valid_i = 1'b0;
    chk("rst_first_held", {wb_valid_o, wb_last_o, wb_rd_o}, {1'b1, 1'b0, 5'd12});
    @(posedge clk_i); #3;
    rst_ni = 1'b0;
    #1 chk("rst_async", {wb_valid_o, busy_o}, 2'b00);
    @(posedge clk_i); #3;
    rst_ni = 1'b1;
    wb_ready_i = 1'b1;
    repeat (4) begin
      @(posedge clk_i); #1;
      chk("rst_no_second", wb_valid_o, 1'b0);
    end

    // Random traffic; the negedge monitor checks every cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_i);
      acc = p_valid_i & p_ready_o;
      @(posedge clk_i); #1;
      if (!p_valid_i || acc) begin
        p_valid_i          = ($urandom_range(0, 3) != 0);
        p_dual_writeback_i = $urandom_range(0, 1) == 1;
        case ($urandom_range(0, 5))
          0: p_rd_i = 5'd0;
          1: p_rd_i = 5'd31;
          2: p_rd_i = 5'd30;
          3: p_rd_i = 5'd1;
          default: p_rd_i = 5'($urandom_range(0, 31));
        endcase
        p_data0_i = $urandom;
        p_data1_i = $urandom;
        p_id_i    = 4'($urandom_range(0, 15));
        p_error_i = $urandom_range(0, 1) == 1;
      end
      wb_ready_i = ($urandom_range(0, 3) != 0);
    end
    p_valid_i  = 1'b0;
    wb_ready_i = 1'b1;
    k = 0;
    while (expq.size() != 0 && k < 10) begin
      @(posedge clk_i); #1;
      k++;
    end
    @(posedge clk_i); #1;
    chk("drain_model_empty", expq.size(), 0);
    chk("drain_idle", wb_valid_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
